gr_sequencer: RTL and testbench



---
 rtl/gr_sequencer_pkg.sv | 17 +
 rtl/gr_sequencer_if.sv | 24 ++
 rtl/gr_sequencer_alu.sv | 35 +++
 rtl/gr_sequencer.sv | 60 ++++++
 tb/tb_gr_sequencer.sv | 122 ++++++++++++
 5 files changed

// File: rtl/gr_sequencer_pkg.sv
// gr_sequencer_pkg: shared widths, opcodes, FSM states and instruction field positions
package gr_sequencer_pkg;
   localparam int DATA_W  = 16;
   localparam int INSTR_W = 16;
   localparam int OPC_LSB = 12;
   localparam int RD_LSB  = 8;
   localparam int RA_LSB  = 4;
   localparam int RB_LSB  = 0;
   typedef enum logic [3:0] {
      OP_NOP = 4'h0, OP_MOV = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
      OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7,
      OP_SHL = 4'h8, OP_SHR = 4'h9, OP_LDI = 4'hA
   } opcode_t;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0, ST_READ = 2'd1, ST_EXEC = 2'd2, ST_WRITE = 2'd3
   } state_t;
endpackage

// File: rtl/gr_sequencer_if.sv
// gr_sequencer_if: instruction handshake plus register-file read/write buses and status
interface gr_sequencer_if;
   import gr_sequencer_pkg::*;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               instr_ready;
   logic [3:0]         aadr;
   logic [3:0]         badr;
   logic [DATA_W-1:0]  bath_a;
   logic [DATA_W-1:0]  bath_b;
   logic [DATA_W-1:0]  bath_c;
   logic [7:0]         latch;
   logic               flag_z;
   logic               done;
   logic               err;
   modport master (
      input  instr, instr_valid, bath_a, bath_b,
      output instr_ready, aadr, badr, bath_c, latch, flag_z, done, err
   );
   modport slave (
      output instr, instr_valid, bath_a, bath_b,
      input  instr_ready, aadr, badr, bath_c, latch, flag_z, done, err
   );
endinterface

// File: rtl/gr_sequencer_alu.sv
// gr_alu: combinational ALU with write/illegal classification of the opcode
module gr_alu
   import gr_sequencer_pkg::*;
(
   input  opcode_t           opcode_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [7:0]        imm8_i,
   output logic [DATA_W-1:0] result_o,
   output logic              is_write_o,
   output logic              is_illegal_o
);
   always_comb begin
      result_o     = '0;
      is_write_o   = 1'b1;
      is_illegal_o = 1'b0;
      case (opcode_i)
         OP_NOP:  is_write_o = 1'b0;
         OP_MOV:  result_o = a_i;
         OP_ADD:  result_o = a_i + b_i;
         OP_SUB:  result_o = a_i - b_i;
         OP_AND:  result_o = a_i & b_i;
         OP_OR:   result_o = a_i | b_i;
         OP_XOR:  result_o = a_i ^ b_i;
         OP_NOT:  result_o = ~a_i;
         OP_SHL:  result_o = a_i << 1;
         OP_SHR:  result_o = a_i >> 1;
         OP_LDI:  result_o = DATA_W'(imm8_i);
         default: begin
            is_write_o   = 1'b0;
            is_illegal_o = 1'b1;
         end
      endcase
   end
endmodule

// File: rtl/gr_sequencer.sv
// gr_sequencer: 4-cycle fetch/read/exec/write control stage in front of the 8-entry register file
module gr_sequencer
   import gr_sequencer_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   gr_sequencer_if.master bus
);
   state_t             state_q, state_d;
   logic [INSTR_W-1:0] ir_q;
   logic [DATA_W-1:0]  opa_q, opb_q, res_q, alu_res;
   logic               flag_z_q, alu_wr, alu_ill;
   gr_alu u_alu (
      .opcode_i     (opcode_t'(ir_q[OPC_LSB +: 4])),
      .a_i          (opa_q),
      .b_i          (opb_q),
      .imm8_i       (ir_q[7:0]),
      .result_o     (alu_res),
      .is_write_o   (alu_wr),
      .is_illegal_o (alu_ill)
   );
   // outputs decode from state_q only, so an async reset clears latch at once
   always_comb begin
      state_d         = state_q;
      bus.instr_ready = 1'b0;
      bus.done        = 1'b0;
      bus.err         = 1'b0;
      bus.latch       = '0;
      state_d         = (state_q == ST_IDLE) ? (bus.instr_valid ? ST_READ : ST_IDLE)
                                             : state_t'(state_q + 2'd1);
      bus.instr_ready = state_q == ST_IDLE;
      bus.done        = state_q == ST_WRITE;
      bus.err         = state_q == ST_WRITE && alu_ill;
      bus.latch       = (state_q == ST_WRITE && alu_wr && !ir_q[RD_LSB+3])
                        ? 8'd1 << ir_q[RD_LSB +: 3] : 8'd0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ir_q     <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         res_q    <= '0;
         flag_z_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && bus.instr_valid) ir_q <= bus.instr;
         if (state_q == ST_READ) begin
            opa_q <= bus.bath_a;
            opb_q <= bus.bath_b;
         end
         if (state_q == ST_EXEC) res_q <= alu_res;
         if (state_q == ST_EXEC && alu_wr) flag_z_q <= alu_res == '0;
      end
   end
   assign bus.aadr   = ir_q[RA_LSB +: 4];
   assign bus.badr   = ir_q[RB_LSB +: 4];
   assign bus.bath_c = res_q;
   assign bus.flag_z = flag_z_q;
endmodule

// File: tb/tb_gr_sequencer.sv
// tb_gr_sequencer: directed checks of gr_sequencer against a behavioural 8-entry register file
module tb_gr_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] gr [8] = '{default: 16'h0000};
   gr_sequencer_if bus ();
   gr_sequencer u_dut (.clk(clk), .rst(rst), .bus(bus.master));
   always #5 clk = ~clk;
   assign bus.bath_a = gr[bus.aadr[3] ? 3'd7 : bus.aadr[2:0]];
   assign bus.bath_b = gr[bus.badr[3] ? 3'd7 : bus.badr[2:0]];
   always @(posedge clk)
      for (int i = 0; i < 8; i++)
         if (bus.latch[i]) gr[i] <= bus.bath_c;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // starts and ends #1 after a rising edge with the DUT in IDLE
   task automatic exec(input string tag, input logic [15:0] ins, input logic [7:0] exp_latch,
                       input logic [15:0] exp_c, input bit chk_c, input bit exp_err, input bit exp_z);
      chk({tag, "_ready"}, 32'(bus.instr_ready), 32'd1);
      bus.instr       = ins;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1 bus.instr_valid = 1'b0;
      chk({tag, "_busy"}, 32'(bus.instr_ready), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk({tag, "_latch"}, 32'(bus.latch), 32'(exp_latch));
      chk({tag, "_done"}, 32'(bus.done), 32'd1);
      chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
      if (chk_c) chk({tag, "_bath_c"}, 32'(bus.bath_c), 32'(exp_c));
      @(posedge clk);
      #1;
      chk({tag, "_done_off"}, 32'(bus.done), 32'd0);
      chk({tag, "_flag_z"}, 32'(bus.flag_z), 32'(exp_z));
   endtask
   initial begin
      bus.instr       = 16'h0000;
      bus.instr_valid = 1'b0;
      #3;
      chk("rst_ready", 32'(bus.instr_ready), 32'd1);
      chk("rst_latch", 32'(bus.latch), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_flag_z", 32'(bus.flag_z), 32'd0);
      chk("rst_bath_c", 32'(bus.bath_c), 32'd0);
      chk("rst_adr", {24'd0, bus.aadr, bus.badr}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      exec("ldi_r1", 16'hA134, 8'h02, 16'h0034, 1, 0, 0);
      exec("ldi_r2", 16'hA212, 8'h04, 16'h0012, 1, 0, 0);
      chk("gr1_ldi", 32'(gr[1]), 32'h0034);
      chk("gr2_ldi", 32'(gr[2]), 32'h0012);
      exec("add_r3", 16'h2312, 8'h08, 16'h0046, 1, 0, 0);
      exec("sub_r4", 16'h3421, 8'h10, 16'hFFDE, 1, 0, 0);
      exec("xor_r5", 16'h6511, 8'h20, 16'h0000, 1, 0, 1);
      exec("ill_c", 16'hC612, 8'h00, 16'h0000, 0, 1, 1);
      chk("gr6_ill", 32'(gr[6]), 32'h0000);
      exec("add_self", 16'h2111, 8'h02, 16'h0068, 1, 0, 0);
      exec("ldi_r9", 16'hA900, 8'h00, 16'h0000, 1, 0, 1);
      exec("ldi_r7", 16'hA75A, 8'h80, 16'h005A, 1, 0, 0);
      exec("mov_hi", 16'h16C0, 8'h40, 16'h005A, 1, 0, 0);
      exec("not_r0", 16'h7020, 8'h01, 16'hFFED, 1, 0, 0);
      exec("shl_r0", 16'h8033, 8'h01, 16'h008C, 1, 0, 0);
      exec("shr_r0", 16'h9044, 8'h01, 16'h7FEF, 1, 0, 0);
      exec("and_r0", 16'h4012, 8'h01, 16'h0000, 1, 0, 1);
      exec("or_r3", 16'h5312, 8'h08, 16'h007A, 1, 0, 0);
      exec("nop", 16'h0000, 8'h00, 16'h0000, 0, 0, 0);
      chk("gr1_final", 32'(gr[1]), 32'h0068);
      chk("gr4_final", 32'(gr[4]), 32'hFFDE);
      chk("gr5_final", 32'(gr[5]), 32'h0000);
      chk("gr6_final", 32'(gr[6]), 32'h005A);
      // valid held high: accepts at cycles 1,5,9; writes visible in cycles 3,7,11
      bus.instr       = 16'hA011;
      bus.instr_valid = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("stream_ready_%0d", i), 32'(bus.instr_ready), 32'(i % 4 == 0));
         chk($sformatf("stream_latch_%0d", i), 32'(bus.latch), (i % 4 == 3) ? 32'd1 << (i / 4) : 32'd0);
         if (i == 1) bus.instr = 16'hA122;
         if (i == 5) bus.instr = 16'hA233;
         if (i == 9) bus.instr = 16'hA344;
      end
      bus.instr_valid = 1'b0;
      chk("stream_gr0", 32'(gr[0]), 32'h0011);
      chk("stream_gr1", 32'(gr[1]), 32'h0022);
      chk("stream_gr2", 32'(gr[2]), 32'h0033);
      chk("stream_gr3", 32'(gr[3]), 32'h007A);
      bus.instr       = 16'hA7FF;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1 bus.instr_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("abort_latch_pre", 32'(bus.latch), 32'h80);
      #2 rst = 1'b1;
      #1;
      chk("abort_latch", 32'(bus.latch), 32'd0);
      chk("abort_ready", 32'(bus.instr_ready), 32'd1);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_bath_c", 32'(bus.bath_c), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_gr7", 32'(gr[7]), 32'h005A);
      chk("post_ready", 32'(bus.instr_ready), 32'd1);
      chk("post_outs", {bus.latch, bus.aadr, bus.badr, 5'd0, bus.flag_z, bus.done, bus.err}, 32'd0);
      chk("post_bath_c", 32'(bus.bath_c), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
